// File: rtl/data_mem_ctrl_if.sv
// Load/store request and response bundle between the core control/datapath and the data memory controller.
interface data_mem_ctrl_if;
  logic        iReq;
  logic        iWe;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic [31:0] oRdData;
  logic        oStall;
  logic        oDone;
  logic        oFault;

  modport master (
    output iReq, iWe, iFunct3, iAddr, iWrData,
    input  oRdData, oStall, oDone, oFault
  );

  modport slave (
    input  iReq, iWe, iFunct3, iAddr, iWrData,
    output oRdData, oStall, oDone, oFault
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory controller: word RAM with byte-lane stores, extended loads,
// a fixed number of wait states per access, and alignment/funct3 fault detection.
module data_mem_ctrl #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic           iClk,
  input  logic           iRst,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LA = AW + 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [LA-1:0] addr_q, addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic [31:0]   mem [DEPTH] = '{default: '0};

  logic          cur_we_c;
  logic [2:0]    cur_funct3_c;
  logic [LA-1:0] cur_addr_c;
  logic [31:0]   cur_wr_data_c;
  logic [AW-1:0] cur_idx_c;
  logic          fault_c;
  logic          enter_resp_c;
  logic          wr_en_c;
  logic [31:0]   rword_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   ld_c;
  logic [3:0]    be_c;
  logic [31:0]   wd_c;
  logic          unused_addr_c;

  assign unused_addr_c = ^bus.iAddr[31:LA];

  // In IDLE the access is decided on the live inputs; afterwards on the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we_c      = bus.iWe;
      cur_funct3_c  = bus.iFunct3;
      cur_addr_c    = bus.iAddr[LA-1:0];
      cur_wr_data_c = bus.iWrData;
    end else begin
      cur_we_c      = we_q;
      cur_funct3_c  = funct3_q;
      cur_addr_c    = addr_q;
      cur_wr_data_c = wr_data_q;
    end
    cur_idx_c = cur_addr_c[LA-1:2];
  end

  always_comb begin
    if (cur_we_c) fault_c = (cur_funct3_c > 3'b010);
    else          fault_c = (cur_funct3_c inside {3'b011, 3'b110, 3'b111});
    if (cur_funct3_c[1:0] == 2'b01 && cur_addr_c[0])          fault_c = 1'b1;
    if (cur_funct3_c[1:0] == 2'b10 && cur_addr_c[1:0] != 2'b00) fault_c = 1'b1;
  end

  // Load lane select and extension.
  always_comb begin
    rword_c = mem[cur_idx_c];
    byte_c  = rword_c[{cur_addr_c[1:0], 3'b000} +: 8];
    half_c  = cur_addr_c[1] ? rword_c[31:16] : rword_c[15:0];
    case (cur_funct3_c)
      3'b000:  ld_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  ld_c = {{16{half_c[15]}}, half_c};
      3'b010:  ld_c = rword_c;
      3'b100:  ld_c = {24'h0, byte_c};
      3'b101:  ld_c = {16'h0, half_c};
      default: ld_c = '0;
    endcase
  end

  // Store byte enables with the data replicated across lanes.
  always_comb begin
    case (cur_funct3_c[1:0])
      2'b00: begin
        be_c = 4'b0001 << cur_addr_c[1:0];
        wd_c = {4{cur_wr_data_c[7:0]}};
      end
      2'b01: begin
        be_c = cur_addr_c[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{cur_wr_data_c[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = cur_wr_data_c;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    rd_data_d    = rd_data_q;
    done_d       = 1'b0;
    fault_d      = 1'b0;
    enter_resp_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.iReq) begin
          we_d      = bus.iWe;
          funct3_d  = bus.iFunct3;
          addr_d    = bus.iAddr[LA-1:0];
          wr_data_d = bus.iWrData;
          if (fault_c || WAIT_CYC == 0) begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_CYC - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp_c) begin
      done_d    = 1'b1;
      fault_d   = fault_c;
      rd_data_d = (fault_c || cur_we_c) ? '0 : ld_c;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  // RAM survives reset; a store only lands on the edge that enters RESP.
  assign wr_en_c = enter_resp_c && cur_we_c && !fault_c && !iRst;

  always_ff @(posedge iClk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[cur_idx_c][8*i +: 8] <= wd_c[8*i +: 8];
      end
    end
  end

  assign bus.oStall  = (state_q == S_IDLE && bus.iReq) || (state_q == S_WAIT);
  assign bus.oRdData = rd_data_q;
  assign bus.oDone   = done_q;
  assign bus.oFault  = fault_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver queues expected responses, monitor checks on every oDone.
module tb_data_mem_ctrl;
  localparam int unsigned WAIT_CYC = 2;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.DEPTH(256), .WAIT_CYC(WAIT_CYC)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Monitor: every completed access must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.oDone) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending access");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", bus.oRdData, e.data);
        check("fault", 32'(bus.oFault), 32'(e.fault));
      end
    end
  end

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_fault);
    int lat, stalls;
    bit got;
    exp_t e;
    lat = 0; stalls = 0; got = 0;
    @(posedge clk); #1;
    bus.iReq = 1'b1; bus.iWe = we; bus.iFunct3 = f3; bus.iAddr = addr; bus.iWrData = wd;
    e.data = exp_data; e.fault = exp_fault;
    sb.push_back(e);
    @(negedge clk);
    if (bus.oStall) stalls++;
    @(posedge clk); #1;
    bus.iReq = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (bus.oStall) stalls++;
      if (bus.oDone) begin got = 1; lat = c; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles (addr %08h)", addr);
    end else begin
      check("latency", 32'(lat), exp_fault ? 32'd1 : 32'(WAIT_CYC + 1));
      check("stall_cycles", 32'(stalls), exp_fault ? 32'd1 : 32'(WAIT_CYC + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iReq = 1'b0; bus.iWe = 1'b0; bus.iFunct3 = 3'b000; bus.iAddr = '0; bus.iWrData = '0;
    #23 rst = 1'b0;
    @(negedge clk);
    check("reset_rd_data", bus.oRdData, 32'h0);
    check("reset_done", 32'(bus.oDone), 32'h0);
    check("reset_fault", 32'(bus.oFault), 32'h0);
    check("reset_stall", 32'(bus.oStall), 32'h0);

    // Word store/load and hold of read data
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (3) @(negedge clk);
    check("rd_data_hold", bus.oRdData, 32'hDEADBEEF);

    // Byte store, signed/unsigned byte loads
    access(1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0);
    access(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    access(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

    // Halfword store and loads
    access(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0);
    access(1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    access(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    access(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    access(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);

    // Faults: misaligned, illegal funct3; RAM must not change
    access(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
    access(1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1);
    access(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    access(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1);
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

    // Reset during WAIT aborts the store
    @(posedge clk); #1;
    bus.iReq = 1'b1; bus.iWe = 1'b1; bus.iFunct3 = 3'b010; bus.iAddr = 32'h20; bus.iWrData = 32'h55;
    @(posedge clk); #1;
    bus.iReq = 1'b0;
    check("wait_stall", 32'(bus.oStall), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("abort_stall", 32'(bus.oStall), 32'h0);
    check("abort_done", 32'(bus.oDone), 32'h0);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    access(1'b0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0);

    // Address wrap
    access(1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0);
    access(1'b0, 3'b010, 32'h000, 32'h0, 32'hA5A5A5A5, 1'b0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256; data RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter WAIT_CYC, default 2; wait states per access, range 0..15.
REQ-003 SHALL have port iClk, input, 1; clock, rising-edge.
REQ-004 SHALL have port iRst, input, 1; reset, asynchronous, active-high.
REQ-005 SHALL have port iReq, input, 1; load/store request from control.
REQ-006 SHALL have port iWe, input, 1; 1 = store, 0 = load.
REQ-007 SHALL have port iFunct3, input, 3; RV32I load/store funct3.
REQ-008 SHALL have port iAddr, input, 32; byte address (datapath ALU result).
REQ-009 SHALL have port iWrData, input, 32; store data (datapath rs2).
REQ-010 SHALL have port oRdData, output, 32; extended load data to the register write-back mux.
REQ-011 SHALL have port oStall, output, 1; freezes PC and register write while high.
REQ-012 SHALL have port oDone, output, 1; one-cycle access-complete pulse.
REQ-013 SHALL have port oFault, output, 1; misaligned or illegal funct3, valid with oDone.

Function
REQ-014 SHALL hold internal RAM of DEPTH x 32 bits, indexed by iAddr[log2(DEPTH)+1:2]; upper address bits are ignored (wrap).
REQ-015 SHALL implement FSM IDLE, WAIT, RESP.
REQ-016 SHALL, when IDLE and iReq=1 at an edge, latch iWe, iFunct3, iAddr and iWrData, then go to WAIT (WAIT_CYC>0) or to RESP (WAIT_CYC=0).
REQ-017 SHALL stay in WAIT for exactly WAIT_CYC cycles using a down-counter, then enter RESP.
REQ-018 SHALL hold RESP for exactly one cycle, then return to IDLE; iReq is ignored in WAIT and RESP.
REQ-019 SHALL drive oStall combinationally = (IDLE and iReq) or WAIT; oStall is 0 in RESP.
REQ-020 SHALL drive oDone = 1 only in RESP; oDone rises WAIT_CYC+1 cycles after the request cycle.
REQ-021 SHALL flag a fault in these cases:
- Halfword access with addr[0]=1.
- Word access with addr[1:0]!=0.
- Load funct3 in {011,110,111}.
- Store funct3 > 010.
REQ-022 SHALL send a faulting request from IDLE directly to RESP with no wait states; in RESP, oFault=1, oRdData=0 and RAM is unchanged.
REQ-023 SHALL commit stores on the edge entering RESP, using byte lanes:
- SB: lane addr[1:0] written with wrdata[7:0].
- SH: lanes {addr[1],0} and {addr[1],1} written with wrdata[15:0].
- SW: all four lanes written.
REQ-024 SHALL register load data on the edge entering RESP, extended as follows:
- LB/LH: sign-extended selected byte/half.
- LBU/LHU: zero-extended selected byte/half.
- LW: full word.
REQ-025 SHALL set oRdData=0 for stores; oRdData holds its value until the next RESP.
REQ-026 SHALL deassert oFault outside RESP.

Reset
REQ-027 SHALL, on iRst, asynchronously force IDLE, clear the counter and latched request, and drive oRdData=0, oDone=0, oFault=0.
REQ-028 SHALL abort a pending access when reset occurs in WAIT; no RAM write occurs.
REQ-029 SHALL NOT clear RAM contents on reset; RAM initialises to zero at time 0.

Verification (WAIT_CYC=2, DEPTH=256)
REQ-030 SW 0xDEADBEEF @0x10, then LW @0x10 -> oRdData=0xDEADBEEF; oDone 3 cycles after the request cycle; oStall high for 3 cycles.
REQ-031 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-032 SH 0x1234 @0x12, then LH @0x12 -> 0x00001234; LW @0x10 -> 0x1234BEEF.
REQ-033 LW @0x11 -> oDone and oFault the next cycle, oRdData=0; SH @0x13 -> oFault=1 and word @0x10 unchanged.
REQ-034 SW 0x55 @0x20 with iRst pulsed during WAIT -> oStall=0 and IDLE immediately; LW @0x20 -> 0x00000000.
REQ-035 SW 0xA5A5A5A5 @0x400, then LW @0x000 -> 0xA5A5A5A5 (address wrap).
